// File: rtl/e_m_registers_pkg.sv
// Shared widths, instruction-type codes and payload layout for the Execute/Memory boundary.
// The width macros may be predefined by the build; otherwise the defaults below apply.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package e_m_registers_pkg;

  localparam int EM_WORD_SIZE       = `WORD_SIZE;
  localparam int EM_INSTR_TYPE_SZ   = `INSTR_TYPE_SZ;
  localparam int EM_ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH;

  typedef enum logic [EM_INSTR_TYPE_SZ-1:0] {
    IT_ALU    = 3'd0,
    IT_LOAD   = 3'd1,
    IT_STORE  = 3'd2,
    IT_BRANCH = 3'd3,
    IT_JUMP   = 3'd4
  } instr_type_e;

  typedef struct packed {
    logic [EM_INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [EM_WORD_SIZE-1:0]       pc;
    logic [2:0]                    funct3;
    logic [EM_WORD_SIZE-1:0]       alu_result;
    logic [EM_WORD_SIZE-1:0]       s2;
    logic [EM_ROB_ENTRY_WIDTH-1:0] rob_id;
  } em_payload_t;

endpackage

// File: rtl/e_m_registers_pipe_reg.sv
// Generic register with load enable and optional synchronous clear (clear wins over enable).
// Latency 1 cycle; holds while en=0.
module e_m_registers_pipe_reg #(
  parameter int W      = 1,
  parameter bit CLR_EN = 1'b0
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (CLR_EN && clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/e_m_registers.sv
// Execute->Memory pipeline register bank: 1-cycle latency; holds only while a valid instruction is stalled.
// Bubbles always load, even under stall. Reset clears valid_out; with E_M_REGS_RESET_DATA_EN it also zeroes data.
module e_m_registers #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       aluResult,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  input  logic                       valid,
  input  logic                       stall,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic [2:0]                 funct3_out,
  output logic [WORD_SIZE-1:0]       aluResult_out,
  output logic [WORD_SIZE-1:0]       s2_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  output logic                       valid_out
);

`ifdef E_M_REGS_RESET_DATA_EN
  localparam bit DATA_CLR = 1'b1;
`else
  localparam bit DATA_CLR = 1'b0;
`endif

  logic wenable;
  assign wenable = ~stall | ~valid;

  e_m_registers_pipe_reg #(.W(INSTR_TYPE_SZ), .CLR_EN(DATA_CLR)) u_type (
    .clk(clk), .en(wenable), .clr(reset), .d(instruction_type), .q(instruction_type_out)
  );

  e_m_registers_pipe_reg #(.W(WORD_SIZE), .CLR_EN(DATA_CLR)) u_pc (
    .clk(clk), .en(wenable), .clr(reset), .d(pc), .q(pc_out)
  );

  e_m_registers_pipe_reg #(.W(3), .CLR_EN(DATA_CLR)) u_funct3 (
    .clk(clk), .en(wenable), .clr(reset), .d(funct3), .q(funct3_out)
  );

  e_m_registers_pipe_reg #(.W(WORD_SIZE), .CLR_EN(DATA_CLR)) u_alu (
    .clk(clk), .en(wenable), .clr(reset), .d(aluResult), .q(aluResult_out)
  );

  e_m_registers_pipe_reg #(.W(WORD_SIZE), .CLR_EN(DATA_CLR)) u_s2 (
    .clk(clk), .en(wenable), .clr(reset), .d(s2), .q(s2_out)
  );

  e_m_registers_pipe_reg #(.W(ROB_ENTRY_WIDTH), .CLR_EN(DATA_CLR)) u_rob (
    .clk(clk), .en(wenable), .clr(reset), .d(rob_id), .q(rob_id_out)
  );

  // The valid bit is always cleared by reset, independent of the data-clear option.
  e_m_registers_pipe_reg #(.W(1), .CLR_EN(1'b1)) u_valid (
    .clk(clk), .en(wenable), .clr(reset), .d(valid), .q(valid_out)
  );

endmodule

// File: tb/tb_e_m_registers.sv
// Directed and randomized check of e_m_registers against a cycle-level model of the bank.
module tb_e_m_registers;
  import e_m_registers_pkg::*;

  localparam int W  = EM_WORD_SIZE;
  localparam int IT = EM_INSTR_TYPE_SZ;
  localparam int RW = EM_ROB_ENTRY_WIDTH;

`ifdef E_M_REGS_RESET_DATA_EN
  localparam bit RST_DATA = 1'b1;
`else
  localparam bit RST_DATA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [IT-1:0] instruction_type;
  logic [W-1:0]  pc;
  logic [2:0]    funct3;
  logic [W-1:0]  aluResult;
  logic [W-1:0]  s2;
  logic [RW-1:0] rob_id;
  logic          valid;
  logic          stall;
  logic [IT-1:0] instruction_type_out;
  logic [W-1:0]  pc_out;
  logic [2:0]    funct3_out;
  logic [W-1:0]  aluResult_out;
  logic [W-1:0]  s2_out;
  logic [RW-1:0] rob_id_out;
  logic          valid_out;

  int checks   = 0;
  int failures = 0;

  em_payload_t exp_data;
  logic        exp_valid;
  bit          data_known = 1'b0;
  bit          started    = 1'b0;

  e_m_registers dut (
    .clk(clk), .reset(reset),
    .instruction_type(instruction_type), .pc(pc), .funct3(funct3),
    .aluResult(aluResult), .s2(s2), .rob_id(rob_id),
    .valid(valid), .stall(stall),
    .instruction_type_out(instruction_type_out), .pc_out(pc_out),
    .funct3_out(funct3_out), .aluResult_out(aluResult_out),
    .s2_out(s2_out), .rob_id_out(rob_id_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Model: a stalled valid instruction is the only thing that blocks a load.
  always @(posedge clk) begin
    bit loads;
    loads = !(stall === 1'b1 && valid === 1'b1);
    if (reset) exp_valid = 1'b0;
    else if (loads) exp_valid = valid;
    if (RST_DATA && reset) begin
      exp_data   = '0;
      data_known = 1'b1;
    end else if (loads) begin
      exp_data.instruction_type = instruction_type;
      exp_data.pc               = pc;
      exp_data.funct3           = funct3;
      exp_data.alu_result       = aluResult;
      exp_data.s2               = s2;
      exp_data.rob_id           = rob_id;
      data_known                = 1'b1;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_wenable", 32'(dut.wenable), 32'(!(stall && valid)));
      check("m_valid_out", 32'(valid_out), 32'(exp_valid));
      if (data_known) begin
        check("m_type", 32'(instruction_type_out), 32'(exp_data.instruction_type));
        check("m_pc", pc_out, exp_data.pc);
        check("m_funct3", 32'(funct3_out), 32'(exp_data.funct3));
        check("m_alu", aluResult_out, exp_data.alu_result);
        check("m_s2", s2_out, exp_data.s2);
        check("m_rob", 32'(rob_id_out), 32'(exp_data.rob_id));
      end
    end
  end

  // Drive one cycle's inputs just after a falling edge, then advance to the next falling edge.
  task automatic apply(input logic [31:0] it, input logic [31:0] p, input logic [31:0] f3,
                       input logic [31:0] alu, input logic [31:0] src2, input logic [31:0] rob,
                       input logic v, input logic st, input logic rst, input logic exp_we);
    #1;
    instruction_type = it[IT-1:0];
    pc               = p[W-1:0];
    funct3           = f3[2:0];
    aluResult        = alu[W-1:0];
    s2               = src2[W-1:0];
    rob_id           = rob[RW-1:0];
    valid            = v;
    stall            = st;
    reset            = rst;
    #1;
    check("wenable", 32'(dut.wenable), 32'(exp_we));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_data(input string tag, input logic [31:0] it, input logic [31:0] p,
                            input logic [31:0] f3, input logic [31:0] alu,
                            input logic [31:0] src2, input logic [31:0] rob);
    check({tag, "_type"}, 32'(instruction_type_out), it);
    check({tag, "_pc"}, pc_out, p);
    check({tag, "_funct3"}, 32'(funct3_out), f3);
    check({tag, "_alu"}, aluResult_out, alu);
    check({tag, "_s2"}, s2_out, src2);
    check({tag, "_rob"}, 32'(rob_id_out), rob);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; stall = 1'b0;
    instruction_type = '0; pc = '0; funct3 = '0; aluResult = '0; s2 = '0; rob_id = '0;
    repeat (2) @(negedge clk);
    check("reset_valid_out", 32'(valid_out), 32'd0);

    apply(1, 1222, 3, 7, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    check_data("load", 1, 1222, 3, 7, 3, 2);
    check("load_valid_out", 32'(valid_out), 32'd1);

    apply(0, 1282, 3, 77, 37, 27, 1'b0, 1'b0, 1'b0, 1'b1);
    check_data("bubble", 0, 1282, 3, 77, 37, 27);
    check("bubble_valid_out", 32'(valid_out), 32'd0);

    // funct3=35 keeps only its low three bits (3)
    apply(1, 122, 35, 57, 53, 52, 1'b0, 1'b1, 1'b0, 1'b1);
    check_data("stall_inv", 1, 122, 3, 57, 53, 52);
    check("stall_inv_valid_out", 32'(valid_out), 32'd0);

    apply(0, 1224, 34, 74, 34, 24, 1'b1, 1'b1, 1'b0, 1'b0);
    check_data("stall_v", 1, 122, 3, 57, 53, 52);
    check("stall_v_valid_out", 32'(valid_out), 32'd0);

    apply(1, 1222, 3, 7, 3, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    if (RST_DATA) check_data("reset", 0, 0, 0, 0, 0, 0);
    else          check_data("reset", 1, 1222, 3, 7, 3, 2);
    check("reset_load_valid_out", 32'(valid_out), 32'd0);

    apply(2, 500, 2, 501, 502, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("pre_rst_stall_valid_out", 32'(valid_out), 32'd1);
    apply(3, 600, 5, 601, 602, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    if (RST_DATA) check_data("rst_stall", 0, 0, 0, 0, 0, 0);
    else          check_data("rst_stall", 2, 500, 2, 501, 502, 5);
    check("rst_stall_valid_out", 32'(valid_out), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic v, st, rst;
      v   = 1'($urandom_range(0, 1));
      st  = 1'($urandom_range(0, 2) != 0);
      rst = 1'($urandom_range(0, 15) == 0);
      apply($urandom_range(0, 4), $urandom, $urandom, $urandom, $urandom, $urandom,
            v, st, rst, !(v && st));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
